aq_axi_lite_master: RTL

AQ_AXI_LITE_MASTER -- requirements
Module: aq_axi_lite_master

---
 rtl/aq_axi_lite_master.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/aq_axi_lite_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aq_axi_lite_master                                        |
// | Description : Single-outstanding AXI4-Lite master driven by a local     |
// |               command/response handshake.                               |
// | Option      : AQ_AXI_LITE_MASTER_TIMEOUT_EN enables the response-wait   |
// |               timeout (TIMEOUT_CYCLES).                                 |
// | Revision    : 1.0                                                       |
// +--------------------------------------------------------------------------+
module aq_axi_lite_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        ACLK,
    input  logic        ARESETN,

    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    input  logic [1:0]  M_AXI_BRESP,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,

    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_RNW,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    input  logic [3:0]  CMD_WSTRB,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic [1:0]  RSP_RESP
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_B    = 3'd2,
        S_AR   = 3'd3,
        S_R    = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;

    logic        w_accept;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_timeout;
    logic        w_rsp_load;
    logic [31:0] w_rsp_rdata_d;
    logic [1:0]  w_rsp_resp_d;

    // Every handshake output is a decode of registered state only.
    assign CMD_READY     = (r_state == S_IDLE);
    assign M_AXI_AWVALID = (r_state == S_WR) && !r_aw_done;
    assign M_AXI_WVALID  = (r_state == S_WR) && !r_w_done;
    assign M_AXI_BREADY  = (r_state == S_B);
    assign M_AXI_ARVALID = (r_state == S_AR);
    assign M_AXI_RREADY  = (r_state == S_R);
    assign RSP_VALID     = (r_state == S_RSP);

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign RSP_RDATA     = r_rsp_rdata;
    assign RSP_RESP      = r_rsp_resp;

    assign w_accept = CMD_VALID && (r_state == S_IDLE);
    assign w_aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs   = M_AXI_WVALID && M_AXI_WREADY;

`ifdef AQ_AXI_LITE_MASTER_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tmo_cnt;

    // Restarts on every state change so each wait phase gets the full budget.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_tmo_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_tmo_cnt <= '0;
        end else if (r_state inside {S_WR, S_B, S_AR, S_R}) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_tmo_cnt == c_tmo_last) &&
                       (r_state inside {S_WR, S_B, S_AR, S_R});
`else
    localparam int c_unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_rsp_load    = 1'b0;
        w_rsp_rdata_d = 32'd0;
        w_rsp_resp_d  = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    w_state_next = CMD_RNW ? S_AR : S_WR;
                end
            end
            S_WR: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = S_B;
                end else if (w_timeout) begin
                    w_state_next = S_RSP;
                    w_rsp_load   = 1'b1;
                    w_rsp_resp_d = 2'b11;
                end
            end
            S_B: begin
                if (M_AXI_BVALID) begin
                    w_state_next = S_RSP;
                    w_rsp_load   = 1'b1;
                    w_rsp_resp_d = M_AXI_BRESP;
                end else if (w_timeout) begin
                    w_state_next = S_RSP;
                    w_rsp_load   = 1'b1;
                    w_rsp_resp_d = 2'b11;
                end
            end
            S_AR: begin
                if (M_AXI_ARREADY) begin
                    w_state_next = S_R;
                end else if (w_timeout) begin
                    w_state_next = S_RSP;
                    w_rsp_load   = 1'b1;
                    w_rsp_resp_d = 2'b11;
                end
            end
            S_R: begin
                if (M_AXI_RVALID) begin
                    w_state_next  = S_RSP;
                    w_rsp_load    = 1'b1;
                    w_rsp_rdata_d = M_AXI_RDATA;
                    w_rsp_resp_d  = M_AXI_RRESP;
                end else if (w_timeout) begin
                    w_state_next = S_RSP;
                    w_rsp_load   = 1'b1;
                    w_rsp_resp_d = 2'b11;
                end
            end
            S_RSP: begin
                if (RSP_READY) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= CMD_ADDR;
                r_wdata   <= CMD_WDATA;
                r_wstrb   <= CMD_WSTRB;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end
            if (w_rsp_load) begin
                r_rsp_rdata <= w_rsp_rdata_d;
                r_rsp_resp  <= w_rsp_resp_d;
            end
        end
    end

endmodule
`default_nettype wire
